// File: rtl/multicycle_cpu_core.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_cpu_core
// Purpose  : Multicycle core, FETCH/DECODE/EXECUTE/MEM/WRITEBACK, req/ack memories
// Revision : 1.0
// ============================================================================
module multicycle_cpu_core #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 16,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc_out,
  output logic              halted,
  output logic              illegal
);

  localparam logic [5:0] c_op_nop  = 6'h00;
  localparam logic [5:0] c_op_add  = 6'h01;
  localparam logic [5:0] c_op_sub  = 6'h02;
  localparam logic [5:0] c_op_and  = 6'h03;
  localparam logic [5:0] c_op_or   = 6'h04;
  localparam logic [5:0] c_op_xor  = 6'h05;
  localparam logic [5:0] c_op_addi = 6'h06;
  localparam logic [5:0] c_op_lw   = 6'h07;
  localparam logic [5:0] c_op_sw   = 6'h08;
  localparam logic [5:0] c_op_beq  = 6'h09;
  localparam logic [5:0] c_op_jal  = 6'h0A;
  localparam logic [5:0] c_op_halt = 6'h3F;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } state_t;

  state_t            r_state, w_next_state;
  logic [31:0]       r_ir;
  logic [PC_W-1:0]   r_pc, r_next_pc;
  logic [DATA_W-1:0] r_a, r_b, r_result;
  logic              r_imem_req, r_dmem_req, r_dmem_we, r_halted, r_illegal;
  logic [DATA_W-1:0] r_dmem_addr, r_dmem_wdata;
  logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];

  logic [5:0]        w_op;
  logic [4:0]        w_rs1, w_rs2, w_rd;
  logic [DATA_W-1:0] w_imm, w_rs1_val, w_rs2_val, w_alu, w_link;
  logic [PC_W-1:0]   w_imm_pc, w_pc_inc, w_target;
  logic              w_legal, w_is_mem, w_writes_rd;

  assign w_op        = r_ir[31:26];
  assign w_rs1       = r_ir[25:21];
  assign w_rs2       = r_ir[20:16];
  assign w_rd        = r_ir[15:11];
  assign w_imm       = {{(DATA_W-11){r_ir[10]}}, r_ir[10:0]};
  assign w_imm_pc    = {{(PC_W-11){r_ir[10]}}, r_ir[10:0]};
  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_legal     = (w_op <= c_op_jal) || (w_op == c_op_halt);
  assign w_is_mem    = (w_op == c_op_lw) || (w_op == c_op_sw);
  assign w_writes_rd = ((w_op != c_op_nop) && (w_op <= c_op_lw)) || (w_op == c_op_jal);

  // r0 and indices beyond NUM_REGS have no storage and read as zero
  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (int'(w_rs1) == i) w_rs1_val = r_regs[i];
      if (int'(w_rs2) == i) w_rs2_val = r_regs[i];
    end
  end

  always_comb begin
    w_link = '0;
    w_link[PC_W-1:0] = w_pc_inc;
  end

  always_comb begin
    w_alu = '0;
    case (w_op)
      c_op_add:  w_alu = r_a + r_b;
      c_op_sub:  w_alu = r_a - r_b;
      c_op_and:  w_alu = r_a & r_b;
      c_op_or:   w_alu = r_a | r_b;
      c_op_xor:  w_alu = r_a ^ r_b;
      c_op_addi: w_alu = r_a + w_imm;
      c_op_jal:  w_alu = w_link;
      default:   w_alu = '0;
    endcase
  end

  always_comb begin
    w_target = w_pc_inc;
    if (w_op == c_op_beq && r_a == r_b) w_target = w_pc_inc + w_imm_pc;
    else if (w_op == c_op_jal)          w_target = r_a[PC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:     if (r_imem_req && imem_ack) w_next_state = S_DECODE;
      S_DECODE:    w_next_state = (w_op == c_op_halt || !w_legal) ? S_HALTED : S_EXECUTE;
      S_EXECUTE:   w_next_state = w_is_mem ? S_MEM : S_WRITEBACK;
      S_MEM:       if (r_dmem_req && dmem_ack) w_next_state = S_WRITEBACK;
      S_WRITEBACK: w_next_state = S_FETCH;
      S_HALTED:    w_next_state = S_HALTED;
      default:     w_next_state = S_FETCH;
    endcase
  end

  // Requests are registered: raised one state early so a zero-wait fetch costs one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ir         <= '0;
      r_pc         <= '0;
      r_next_pc    <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_imem_req   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_halted     <= 1'b0;
      r_illegal    <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_imem_req) begin
            r_imem_req <= 1'b1;
          end else if (imem_ack) begin
            r_ir       <= imem_rdata;
            r_imem_req <= 1'b0;
          end
        end
        S_DECODE: begin
          r_a <= w_rs1_val;
          r_b <= w_rs2_val;
          if (w_op == c_op_halt) r_halted  <= 1'b1;
          else if (!w_legal)     r_illegal <= 1'b1;
        end
        S_EXECUTE: begin
          r_result  <= w_alu;
          r_next_pc <= w_target;
          if (w_is_mem) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= (w_op == c_op_sw);
            r_dmem_addr  <= r_a + w_imm;
            r_dmem_wdata <= r_b;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (!r_dmem_we) r_result <= dmem_rdata;
          end
        end
        S_WRITEBACK: begin
          r_pc       <= r_next_pc;
          r_imem_req <= 1'b1;
          if (w_writes_rd) begin
            for (int i = 1; i < NUM_REGS; i++)
              if (int'(w_rd) == i) r_regs[i] <= r_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign pc_out     = r_pc;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign halted     = r_halted;
  assign illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_cpu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_cpu_core
// Purpose  : Self-checking bench: ALU vector table plus hand-written sequences
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_cpu_core;
  localparam int DATA_W = 32;
  localparam int PC_W   = 16;
  localparam logic [5:0] c_nop = 6'h00, c_add = 6'h01, c_sub = 6'h02, c_and = 6'h03;
  localparam logic [5:0] c_or = 6'h04, c_xor = 6'h05, c_addi = 6'h06, c_lw = 6'h07;
  localparam logic [5:0] c_sw = 6'h08, c_beq = 6'h09, c_jal = 6'h0A, c_halt = 6'h3F;

  logic clk = 1'b0;
  logic reset;
  logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, illegal;
  logic [PC_W-1:0] imem_addr, pc_out;
  logic [31:0] imem_rdata;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;

  multicycle_cpu_core #(.DATA_W(DATA_W), .PC_W(PC_W), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc_out(pc_out), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
  typedef struct { logic [5:0] op; logic [31:0] a; logic [31:0] b; int imm; logic [31:0] exp; } vec_t;

  int checks = 0, failures = 0, cycle = 0;
  int imem_wait = 0, dmem_wait = 0, icnt = 0, dcnt = 0, i_unstable = 0, d_unstable = 0;
  bit imem_force = 0, dmem_force = 0, i_prev_valid = 0, d_prev_valid = 0;
  logic [PC_W-1:0] i_prev;
  logic [64:0] d_prev;
  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:255];
  logic [PC_W-1:0] fetch_addr_q[$];
  int fetch_cyc_q[$];
  logic dacc_we_q[$];
  logic [31:0] dacc_addr_q[$];
  st_t exp_q[$];
  st_t e;
  vec_t vecs[8];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] enc(logic [5:0] op, int rd, int rs1, int rs2, int imm);
    logic [31:0] w;
    w = {op, rs1[4:0], rs2[4:0], rd[4:0], imm[10:0]};
    return w;
  endfunction

  always @(posedge clk) cycle++;

  // Instruction memory responder with programmable wait states
  always @(negedge clk) begin
    if (imem_force) begin
      imem_ack = 1'b1; imem_rdata = 32'h5400_0000;
    end else if (imem_req && reset) begin
      if (i_prev_valid && imem_addr != i_prev) i_unstable++;
      i_prev = imem_addr; i_prev_valid = 1'b1;
      if (icnt >= imem_wait) begin
        imem_ack = 1'b1; imem_rdata = imem[imem_addr[5:0]]; icnt = 0; i_prev_valid = 1'b0;
        fetch_addr_q.push_back(imem_addr); fetch_cyc_q.push_back(cycle);
      end else begin
        imem_ack = 1'b0; icnt++;
      end
    end else begin
      imem_ack = 1'b0; icnt = 0; i_prev_valid = 1'b0;
    end
  end

  // Data memory responder; stores are checked against the scoreboard as they complete
  always @(negedge clk) begin
    if (dmem_force) begin
      dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    end else if (dmem_req && reset) begin
      if (d_prev_valid && {dmem_we, dmem_addr, dmem_wdata} != d_prev) d_unstable++;
      d_prev = {dmem_we, dmem_addr, dmem_wdata}; d_prev_valid = 1'b1;
      if (dcnt >= dmem_wait) begin
        dmem_ack = 1'b1; dcnt = 0; d_prev_valid = 1'b0;
        dacc_we_q.push_back(dmem_we); dacc_addr_q.push_back(dmem_addr);
        if (dmem_we) begin
          dmem[dmem_addr[7:0]] = dmem_wdata;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected store: addr 0x%0h data 0x%0h, none required", dmem_addr, dmem_wdata);
          end else begin
            e = exp_q.pop_front();
            check("store addr", dmem_addr, e.addr);
            check("store data", dmem_wdata, e.data);
          end
        end else begin
          dmem_rdata = dmem[dmem_addr[7:0]];
        end
      end else begin
        dmem_ack = 1'b0; dcnt++;
      end
    end else begin
      dmem_ack = 1'b0; dcnt = 0; d_prev_valid = 1'b0;
    end
  end

  function automatic void clear_logs();
    fetch_addr_q.delete(); fetch_cyc_q.delete(); dacc_we_q.delete(); dacc_addr_q.delete();
    i_unstable = 0; d_unstable = 0;
  endfunction

  function automatic void clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = enc(c_halt, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    exp_q.delete();
    clear_logs();
  endfunction

  task automatic start();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    clear_logs();
  endtask

  task automatic run_to_stop(input string name, input int budget, input logic [1:0] flags);
    int n = 0;
    while (!(halted || illegal) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    check({name, " stop flags"}, {halted, illegal}, flags);
    check({name, " stores done"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PC_W-1:0] exp_f[12];
    int req_cnt;
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;

    // Reset with acks forced high; the stray ack at the release edge must be ignored
    clear_prog(); imem_force = 1; dmem_force = 1;
    imem[0] = enc(c_nop, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset ctrl outputs", {imem_req, dmem_req, dmem_we, halted, illegal}, 5'b0);
    check("reset pc_out", pc_out, 0);
    check("reset dmem addr/wdata", {dmem_addr, dmem_wdata}, 0);
    reset = 1'b1; clear_logs();
    @(posedge clk); #1;
    check("imem_req 1 cycle after release", {imem_req, imem_addr}, {1'b1, 16'h0});
    imem_force = 0; dmem_force = 0;
    run_to_stop("reset prog", 50, 2'b10);
    check("reset prog pc_out", pc_out, 1);

    // ALU vector table: LW r1,0; LW r2,1; OP r3; SW r3,2; HALT
    vecs[0] = '{c_add,  32'hFFFF_FFFF, 32'h0000_0002, 0,     32'h0000_0001};
    vecs[1] = '{c_sub,  32'h0000_0005, 32'h0000_0007, 0,     32'hFFFF_FFFE};
    vecs[2] = '{c_and,  32'hF0F0_1234, 32'h0FF0_FF00, 0,     32'h00F0_1200};
    vecs[3] = '{c_or,   32'hF000_0001, 32'h0000_0F10, 0,     32'hF000_0F11};
    vecs[4] = '{c_xor,  32'hAAAA_5555, 32'hFFFF_0000, 0,     32'h5555_5555};
    vecs[5] = '{c_addi, 32'h7FFF_FFFF, 32'h0,         1,     32'h8000_0000};
    vecs[6] = '{c_addi, 32'h0000_0064, 32'h0,         -1024, 32'hFFFF_FC64};
    vecs[7] = '{c_addi, 32'h0000_0000, 32'h0,         1023,  32'h0000_03FF};
    for (int v = 0; v < 8; v++) begin
      clear_prog();
      imem[0] = enc(c_lw, 1, 0, 0, 0);
      imem[1] = enc(c_lw, 2, 0, 0, 1);
      imem[2] = (vecs[v].op == c_addi) ? enc(c_addi, 3, 1, 0, vecs[v].imm) : enc(vecs[v].op, 3, 1, 2, 0);
      imem[3] = enc(c_sw, 0, 0, 3, 2);
      dmem[0] = vecs[v].a; dmem[1] = vecs[v].b;
      dmem_wait = v % 3; imem_wait = v % 2;
      exp_q.push_back('{addr: 32'd2, data: vecs[v].exp});
      start();
      run_to_stop($sformatf("vec%0d", v), 300, 2'b10);
      check($sformatf("vec%0d pc_out", v), pc_out, 4);
    end

    // Arithmetic sequence with zero-wait memories: 4 cycles per ALU instruction
    clear_prog(); imem_wait = 0; dmem_wait = 0;
    imem[0] = enc(c_addi, 1, 0, 0, 5);
    imem[1] = enc(c_addi, 2, 0, 0, -3);
    imem[2] = enc(c_add, 3, 1, 2, 0);
    imem[3] = enc(c_sub, 4, 2, 1, 0);
    imem[4] = enc(c_sw, 0, 0, 3, 'h30);
    imem[5] = enc(c_sw, 0, 0, 4, 'h31);
    exp_q.push_back('{addr: 32'h30, data: 32'h2});
    exp_q.push_back('{addr: 32'h31, data: 32'hFFFF_FFF8});
    start();
    run_to_stop("arith", 200, 2'b10);
    check("arith fetch count", fetch_cyc_q.size(), 7);
    for (int k = 0; k < 4; k++)
      if (k + 1 < fetch_cyc_q.size())
        check($sformatf("arith latency%0d", k), fetch_cyc_q[k+1] - fetch_cyc_q[k], 4);
    if (fetch_cyc_q.size() > 5) check("zero-wait SW latency", fetch_cyc_q[5] - fetch_cyc_q[4], 5);

    // Store/load with two dmem wait cycles
    clear_prog(); dmem_wait = 2;
    imem[0] = enc(c_addi, 1, 0, 0, 'h10);
    imem[1] = enc(c_addi, 2, 0, 0, 'hAB);
    imem[2] = enc(c_sw, 0, 1, 2, 4);
    imem[3] = enc(c_lw, 5, 1, 0, 4);
    imem[4] = enc(c_sw, 0, 0, 5, 'h40);
    exp_q.push_back('{addr: 32'h14, data: 32'hAB});
    exp_q.push_back('{addr: 32'h40, data: 32'hAB});
    start();
    run_to_stop("memwait", 200, 2'b10);
    check("memwait access count", dacc_we_q.size(), 3);
    if (dacc_we_q.size() >= 2) begin
      check("memwait we sequence", {dacc_we_q[0], dacc_we_q[1]}, 2'b10);
      check("memwait LW addr", dacc_addr_q[1], 32'h14);
    end
    if (fetch_cyc_q.size() >= 5) begin
      check("SW latency with 2 waits", fetch_cyc_q[3] - fetch_cyc_q[2], 7);
      check("LW latency with 2 waits", fetch_cyc_q[4] - fetch_cyc_q[3], 7);
    end
    check("dmem req stable during waits", d_unstable, 0);

    // Control flow: BEQ taken / not taken, JAL call and return
    clear_prog(); dmem_wait = 0; imem_wait = 1;
    imem[0]    = enc(c_addi, 1, 0, 0, 1);
    imem[1]    = enc(c_addi, 7, 0, 0, 'h20);
    imem[2]    = enc(c_nop, 0, 0, 0, 0);
    imem[3]    = enc(c_beq, 0, 0, 0, 2);
    imem[6]    = enc(c_beq, 0, 1, 0, 5);
    imem[7]    = enc(c_nop, 0, 0, 0, 0);
    imem[8]    = enc(c_nop, 0, 0, 0, 0);
    imem[9]    = enc(c_jal, 31, 7, 0, 0);
    imem['h20] = enc(c_sw, 0, 0, 31, 'h50);
    imem['h21] = enc(c_jal, 0, 31, 0, 0);
    imem[10]   = enc(c_sw, 0, 0, 0, 'h51);
    exp_q.push_back('{addr: 32'h50, data: 32'd10});
    exp_q.push_back('{addr: 32'h51, data: 32'd0});
    exp_f = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd6, 16'd7, 16'd8, 16'd9, 16'h20, 16'h21, 16'd10, 16'd11};
    start();
    run_to_stop("ctrl", 300, 2'b10);
    check("ctrl fetch count", fetch_addr_q.size(), 12);
    for (int k = 0; k < 12; k++)
      check($sformatf("ctrl fetch%0d", k), (k < fetch_addr_q.size()) ? fetch_addr_q[k] : 16'hFFFF, exp_f[k]);
    check("ctrl pc_out", pc_out, 11);
    check("imem addr stable during waits", i_unstable, 0);

    // HALT at pc 2: terminal, no further fetches
    clear_prog(); imem_wait = 0;
    imem[0] = enc(c_nop, 0, 0, 0, 0);
    imem[1] = enc(c_nop, 0, 0, 0, 0);
    start();
    run_to_stop("halt", 100, 2'b10);
    check("halt pc_out", pc_out, 2);
    req_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (imem_req || dmem_req) req_cnt++;
    end
    check("halt no requests", req_cnt, 0);

    // Undefined opcode 0x15
    clear_prog();
    imem[0] = enc(c_nop, 0, 0, 0, 0);
    imem[1] = enc(6'h15, 1, 2, 3, 0);
    start();
    run_to_stop("illegal", 100, 2'b01);
    check("illegal pc_out", pc_out, 1);

    // Reset during a FETCH wait, stray ack afterwards, then normal restart
    clear_prog(); imem_wait = 100;
    imem[0] = enc(c_nop, 0, 0, 0, 0);
    start();
    repeat (4) @(posedge clk);
    #1;
    check("midfetch req pending", imem_req, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midfetch req dropped", imem_req, 0);
    imem_force = 1;
    @(posedge clk); #1;
    reset = 1'b1; clear_logs(); imem_wait = 0;
    @(posedge clk); #1;
    imem_force = 0;
    run_to_stop("midfetch", 100, 2'b10);
    check("midfetch pc_out", pc_out, 1);
    check("midfetch restart addr", (fetch_addr_q.size() > 0) ? fetch_addr_q[0] : 16'hFFFF, 0);

    // Reset during a MEM wait; registers must be cleared on restart
    clear_prog(); dmem_wait = 100;
    imem[0] = enc(c_addi, 1, 0, 0, 7);
    imem[1] = enc(c_sw, 0, 0, 1, 'h60);
    start();
    for (int n = 0; n < 30 && !dmem_req; n++) begin
      @(posedge clk); #1;
    end
    check("midmem req seen", {dmem_req, dmem_we}, 2'b11);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("midmem req dropped", {dmem_req, dmem_we}, 2'b00);
    dmem_force = 1;
    imem[0] = enc(c_sw, 0, 0, 1, 'h61);
    imem[1] = enc(c_halt, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1; clear_logs(); dmem_wait = 0;
    exp_q.push_back('{addr: 32'h61, data: 32'h0});
    @(posedge clk); #1;
    dmem_force = 0;
    run_to_stop("midmem", 100, 2'b10);
    check("midmem aborted store absent", dmem[8'h60], 0);
    check("midmem restart addr", (fetch_addr_q.size() > 0) ? fetch_addr_q[0] : 16'hFFFF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
